// File: rtl/stream_arb_if.sv
// Handshake bundle between the stream slaves, the per-master arbiter and the crossbar commutator.
// The arbiter connects to the master modport; the modport named slave mirrors it.
interface stream_arb_if #(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
);
  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i;
  logic [S_DATA_COUNT-1:0]                   s_valid_i;
  logic [S_DATA_COUNT-1:0]                   s_last_i;
  logic [M_DATA_COUNT-1:0]                   m_ready_i;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req_o;
  logic [S_DATA_COUNT-1:0]                   s_ready_o;

  modport master (
    input  s_dest_i,
    input  s_valid_i,
    input  s_last_i,
    input  m_ready_i,
    output req_o,
    output s_ready_o
  );

  modport slave (
    output s_dest_i,
    output s_valid_i,
    output s_last_i,
    output m_ready_i,
    input  req_o,
    input  s_ready_o
  );
endinterface

// File: rtl/stream_arb.sv
// Per-master round-robin packet arbiter: holds a one-hot slave grant per master until the last beat.
// Optional feature macro STREAM_ARB_DROP_INVALID_EN: sink packets whose destination is out of range.
module stream_arb #(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  stream_arb_if.master bus
);
  localparam int S  = S_DATA_COUNT;
  localparam int M  = M_DATA_COUNT;
  localparam int PW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q [M];
  state_e              state_d [M];
  logic [M-1:0][S-1:0] grant_q;
  logic [M-1:0][S-1:0] grant_d;
  logic [M-1:0][PW-1:0] ptr_q;
  logic [M-1:0][PW-1:0] ptr_d;
  logic [S-1:0]        drop_q;
  logic [S-1:0]        drop_d;
  logic [S-1:0]        owned;
  logic [S-1:0]        taken;
  int                  rr_idx;
  logic [M-1:0][S-1:0] req;
  logic [S-1:0]        s_ready;

  function automatic logic [PW-1:0] ptr_after(input logic [S-1:0] onehot);
    int nxt;
    nxt = 0;
    for (int i = 0; i < S; i++) begin
      if (onehot[i]) begin
        nxt = (i + 1 == S) ? 0 : i + 1;
      end else begin
        nxt = nxt;
      end
    end
    return PW'(nxt);
  endfunction

  // State, grant, pointer and drop registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < M; j++) begin
        state_q[j] <= IDLE;
      end
      grant_q <= '0;
      ptr_q   <= '0;
      drop_q  <= '0;
    end else begin
      for (int j = 0; j < M; j++) begin
        state_q[j] <= state_d[j];
      end
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  // A slave already held by any master (or being sunk) is not a candidate anywhere
  always_comb begin
    owned = drop_q;
    for (int j = 0; j < M; j++) begin
      owned = owned | grant_q[j];
    end
  end

  // Per-master next state; 'taken' lets the lowest master index win a contested slave
  always_comb begin
    taken  = owned;
    rr_idx = 0;
    for (int j = 0; j < M; j++) begin
      state_d[j] = state_q[j];
      grant_d[j] = grant_q[j];
      ptr_d[j]   = ptr_q[j];
      case (state_q[j])
        IDLE: begin
          for (int k = 0; k < S; k++) begin
            rr_idx = int'(ptr_q[j]) + k;
            rr_idx = (rr_idx >= S) ? rr_idx - S : rr_idx;
            if (state_d[j] == IDLE && bus.s_valid_i[rr_idx] && !taken[rr_idx] &&
                bus.s_dest_i[rr_idx] == T_DEST_WIDTH'(j)) begin
              state_d[j]         = BUSY;
              grant_d[j]         = '0;
              grant_d[j][rr_idx] = 1'b1;
              taken[rr_idx]      = 1'b1;
            end else begin
              taken = taken;
            end
          end
        end
        BUSY: begin
          if (bus.m_ready_i[j] && |(grant_q[j] & bus.s_valid_i & bus.s_last_i)) begin
            state_d[j] = IDLE;
            grant_d[j] = '0;
            ptr_d[j]   = ptr_after(grant_q[j]);
          end else begin
            state_d[j] = BUSY;
          end
        end
        default: begin
          state_d[j] = IDLE;
          grant_d[j] = '0;
        end
      endcase
    end
  end

  // Drop state: out-of-range packets are sunk until their last beat
  always_comb begin
    drop_d = '0;
    for (int i = 0; i < S; i++) begin
`ifdef STREAM_ARB_DROP_INVALID_EN
      if (drop_q[i]) begin
        drop_d[i] = !(bus.s_valid_i[i] && bus.s_last_i[i]);
      end else begin
        drop_d[i] = !owned[i] && bus.s_valid_i[i] &&
                    (32'(bus.s_dest_i[i]) >= 32'(M_DATA_COUNT));
      end
`else
      drop_d[i] = 1'b0;
`endif
    end
  end

  // Outputs depend on registered grant plus m_ready; s_dest never reaches them directly
  always_comb begin
    req     = '0;
    s_ready = drop_q;
    for (int j = 0; j < M; j++) begin
      if (state_q[j] == BUSY) begin
        req[j]  = grant_q[j];
        s_ready = s_ready | (grant_q[j] & {S{bus.m_ready_i[j]}});
      end else begin
        req[j]  = '0;
      end
    end
  end

  assign bus.req_o     = req;
  assign bus.s_ready_o = s_ready;
endmodule

// File: tb/tb_stream_arb.sv
// Self-checking bench for stream_arb: vector table, corner-case sequences and random traffic
// compared against an index-based reference model.
module tb_stream_arb;
  localparam int S  = 2;
  localparam int M  = 3;
  localparam int TW = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  stream_arb_if #(.S_DATA_COUNT(S), .M_DATA_COUNT(M), .T_DEST_WIDTH(TW)) bus ();

  stream_arb #(.S_DATA_COUNT(S), .M_DATA_COUNT(M), .T_DEST_WIDTH(TW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  int own_m  [M];
  int ptr_m  [M];
  bit drop_m [S];
  logic [1:0] seen_rdy;

  typedef struct packed {
    logic [1:0] v;
    logic [1:0] l;
    logic [1:0] d0;
    logic [1:0] d1;
    logic [2:0] mr;
    logic [5:0] ereq;
    logic [1:0] erdy;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [1:0] d0,
                       input logic [1:0] d1, input logic [2:0] mr);
    bus.s_valid_i = v;
    bus.s_last_i  = l;
    bus.s_dest_i  = {d1, d0};
    bus.m_ready_i = mr;
  endtask

  task automatic model_reset();
    for (int j = 0; j < M; j++) begin
      own_m[j] = -1;
      ptr_m[j] = 0;
    end
    for (int i = 0; i < S; i++) drop_m[i] = 1'b0;
  endtask

  function automatic logic [M-1:0][S-1:0] model_req();
    logic [M-1:0][S-1:0] r;
    r = '0;
    for (int j = 0; j < M; j++) if (own_m[j] >= 0) r[j][own_m[j]] = 1'b1;
    return r;
  endfunction

  function automatic logic [S-1:0] model_rdy();
    logic [S-1:0] r;
    r = '0;
    for (int j = 0; j < M; j++) if (own_m[j] >= 0) r[own_m[j]] = bus.m_ready_i[j];
    for (int i = 0; i < S; i++) if (drop_m[i]) r[i] = 1'b1;
    return r;
  endfunction

  // Advance the reference by one clock edge using the inputs presented in this cycle.
  task automatic model_step();
    int new_own [M];
    bit busy0 [S];
    bit taken [S];
    int i;
    for (int s = 0; s < S; s++) busy0[s] = drop_m[s];
    for (int j = 0; j < M; j++) if (own_m[j] >= 0) busy0[own_m[j]] = 1'b1;
    for (int s = 0; s < S; s++) taken[s] = busy0[s];
    for (int j = 0; j < M; j++) begin
      new_own[j] = own_m[j];
      if (own_m[j] >= 0) begin
        if (bus.s_valid_i[own_m[j]] && bus.m_ready_i[j] && bus.s_last_i[own_m[j]]) begin
          ptr_m[j]   = (own_m[j] + 1) % S;
          new_own[j] = -1;
        end
      end else begin
        for (int k = 0; k < S; k++) begin
          i = (ptr_m[j] + k) % S;
          if (new_own[j] < 0 && bus.s_valid_i[i] && !taken[i] && int'(bus.s_dest_i[i]) == j) begin
            new_own[j] = i;
            taken[i]   = 1'b1;
          end
        end
      end
    end
`ifdef STREAM_ARB_DROP_INVALID_EN
    for (int s = 0; s < S; s++) begin
      if (drop_m[s]) begin
        if (bus.s_valid_i[s] && bus.s_last_i[s]) drop_m[s] = 1'b0;
      end else if (!busy0[s] && bus.s_valid_i[s] && int'(bus.s_dest_i[s]) >= M) begin
        drop_m[s] = 1'b1;
      end
    end
`endif
    for (int j = 0; j < M; j++) own_m[j] = new_own[j];
  endtask

  // One clock cycle: compare against the model (and optional constants), then advance.
  task automatic cyc(input string name, input bit has_exp, input logic [5:0] ereq,
                     input logic [1:0] erdy);
    @(negedge clk_i);
    chk({name, ":req"}, 32'(bus.req_o), 32'(model_req()));
    chk({name, ":rdy"}, 32'(bus.s_ready_o), 32'(model_rdy()));
    if (has_exp) begin
      chk({name, ":req_const"}, 32'(bus.req_o), 32'(ereq));
      chk({name, ":rdy_const"}, 32'(bus.s_ready_o), 32'(erdy));
    end
    seen_rdy = bus.s_ready_o;
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 2'd0, 2'd0, 3'b000);
    rst_i = 1'b1;
    model_reset();
    @(negedge clk_i);
    chk("reset:req", 32'(bus.req_o), 32'd0);
    chk("reset:rdy", 32'(bus.s_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    logic [1:0] cnt [S];
    logic [1:0] lst;
    logic [1:0] r0;

    // single 3-beat packet on master 1, then m_ready stall on master 2
    tbl[0]  = '{v:2'b10, l:2'b00, d0:2'd0, d1:2'd1, mr:3'b111, ereq:6'b000000, erdy:2'b00};
    tbl[1]  = '{v:2'b10, l:2'b00, d0:2'd0, d1:2'd1, mr:3'b111, ereq:6'b001000, erdy:2'b10};
    tbl[2]  = '{v:2'b10, l:2'b00, d0:2'd0, d1:2'd1, mr:3'b111, ereq:6'b001000, erdy:2'b10};
    tbl[3]  = '{v:2'b10, l:2'b10, d0:2'd0, d1:2'd1, mr:3'b111, ereq:6'b001000, erdy:2'b10};
    tbl[4]  = '{v:2'b00, l:2'b00, d0:2'd0, d1:2'd1, mr:3'b111, ereq:6'b000000, erdy:2'b00};
    tbl[5]  = '{v:2'b01, l:2'b00, d0:2'd2, d1:2'd0, mr:3'b011, ereq:6'b000000, erdy:2'b00};
    tbl[6]  = '{v:2'b01, l:2'b00, d0:2'd2, d1:2'd0, mr:3'b011, ereq:6'b010000, erdy:2'b00};
    tbl[7]  = '{v:2'b01, l:2'b00, d0:2'd2, d1:2'd0, mr:3'b011, ereq:6'b010000, erdy:2'b00};
    tbl[8]  = '{v:2'b01, l:2'b00, d0:2'd2, d1:2'd0, mr:3'b011, ereq:6'b010000, erdy:2'b00};
    tbl[9]  = '{v:2'b01, l:2'b00, d0:2'd2, d1:2'd0, mr:3'b011, ereq:6'b010000, erdy:2'b00};
    tbl[10] = '{v:2'b01, l:2'b01, d0:2'd2, d1:2'd0, mr:3'b111, ereq:6'b010000, erdy:2'b01};
    tbl[11] = '{v:2'b00, l:2'b00, d0:2'd2, d1:2'd0, mr:3'b111, ereq:6'b000000, erdy:2'b00};

    do_reset();
    for (int t = 0; t < 12; t++) begin
      drive(tbl[t].v, tbl[t].l, tbl[t].d0, tbl[t].d1, tbl[t].mr);
      cyc("tbl", 1'b1, tbl[t].ereq, tbl[t].erdy);
    end

    // two slaves contend for master 0 with 2-beat packets: 0,1,0,1 with one idle cycle between
    do_reset();
    cnt[0] = 2'd0;
    cnt[1] = 2'd0;
    for (int n = 0; n < 12; n++) begin
      lst = {cnt[1] == 2'd1, cnt[0] == 2'd1};
      drive(2'b11, lst, 2'd0, 2'd0, 3'b111);
      r0 = (n % 3 == 0) ? 2'b00 : (((n / 3) % 2 == 0) ? 2'b01 : 2'b10);
      cyc("rr", 1'b1, {4'b0000, r0}, r0);
      for (int i = 0; i < S; i++) begin
        if (seen_rdy[i]) cnt[i] = lst[i] ? 2'd0 : cnt[i] + 2'd1;
      end
    end

    // destination changes mid-packet: grant stays on master 0 until last
    do_reset();
    drive(2'b01, 2'b00, 2'd0, 2'd0, 3'b111); cyc("dest_chg", 1'b1, 6'b000000, 2'b00);
    drive(2'b01, 2'b00, 2'd2, 2'd0, 3'b111); cyc("dest_chg", 1'b1, 6'b000001, 2'b01);
    drive(2'b01, 2'b00, 2'd2, 2'd0, 3'b111); cyc("dest_chg", 1'b1, 6'b000001, 2'b01);
    drive(2'b01, 2'b01, 2'd2, 2'd0, 3'b111); cyc("dest_chg", 1'b1, 6'b000001, 2'b01);
    drive(2'b01, 2'b00, 2'd2, 2'd0, 3'b111); cyc("dest_chg", 1'b1, 6'b000000, 2'b00);
    drive(2'b01, 2'b01, 2'd2, 2'd0, 3'b111); cyc("dest_chg", 1'b1, 6'b010000, 2'b01);
    drive(2'b00, 2'b00, 2'd2, 2'd0, 3'b111); cyc("dest_chg", 1'b1, 6'b000000, 2'b00);

    // async reset while busy; arbitration restarts from pointer 0
    do_reset();
    drive(2'b01, 2'b01, 2'd0, 2'd0, 3'b111); cyc("rst_mid", 1'b1, 6'b000000, 2'b00);
    drive(2'b01, 2'b01, 2'd0, 2'd0, 3'b111); cyc("rst_mid", 1'b1, 6'b000001, 2'b01);
    drive(2'b11, 2'b00, 2'd0, 2'd0, 3'b111); cyc("rst_mid", 1'b1, 6'b000000, 2'b00);
    @(negedge clk_i);
    chk("rst_mid:busy_req", 32'(bus.req_o), 32'(6'b000010));
    chk("rst_mid:busy_rdy", 32'(bus.s_ready_o), 32'(2'b10));
    rst_i = 1'b1;
    #1;
    chk("rst_mid:async_req", 32'(bus.req_o), 32'd0);
    chk("rst_mid:async_rdy", 32'(bus.s_ready_o), 32'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    chk("rst_mid:held_req", 32'(bus.req_o), 32'd0);
    rst_i = 1'b0;
    cyc("rst_mid:after", 1'b1, 6'b000000, 2'b00);
    cyc("rst_mid:after", 1'b1, 6'b000001, 2'b01);

    // out-of-range destination
    do_reset();
`ifdef STREAM_ARB_DROP_INVALID_EN
    drive(2'b01, 2'b00, 2'd3, 2'd0, 3'b111); cyc("drop", 1'b1, 6'b000000, 2'b00);
    drive(2'b01, 2'b00, 2'd3, 2'd0, 3'b111); cyc("drop", 1'b1, 6'b000000, 2'b01);
    drive(2'b01, 2'b01, 2'd3, 2'd0, 3'b111); cyc("drop", 1'b1, 6'b000000, 2'b01);
    drive(2'b00, 2'b00, 2'd3, 2'd0, 3'b111); cyc("drop", 1'b1, 6'b000000, 2'b00);
`else
    for (int n = 0; n < 20; n++) begin
      drive(2'b01, 2'b01, 2'd3, 2'd0, 3'b111);
      cyc("bad_dest", 1'b1, 6'b000000, 2'b00);
    end
`endif

    // random traffic against the reference model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)),
            {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0)});
      cyc("rand", 1'b0, 6'b000000, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
